// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port SRAM between the fetch port and the data port; data has priority.
// Latency: a single access stalls its requester for MEM_LAT+2 cycles (grant, issue, MEM_LAT waits).
// Backpressure: im_stall/dm_stall stay high until the access finishes; results are held until the pipeline advances.
module mem_port_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              im_req,
    input  logic [31:0]       im_addr,
    output logic [31:0]       im_rdata,
    output logic              im_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_bweb,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_stall,
    output logic              mem_cs,
    output logic              mem_web,
    output logic [3:0]        mem_bweb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_di,
    input  logic [31:0]       mem_do
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic       OWN_IM   = 1'b0;
    localparam logic       OWN_DM   = 1'b1;
    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    state_t     state;
    logic       owner;
    logic [2:0] cnt;
    logic       im_done;
    logic       dm_done;
    logic       owner_req;
    logic       advance;

    // Byte-offset bits and address bits above the SRAM depth are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{im_addr[31:ADDR_W+2], im_addr[1:0],
                                dm_addr[31:ADDR_W+2], dm_addr[1:0]};

    assign im_stall  = im_req & ~im_done & ~rst;
    assign dm_stall  = dm_req & ~dm_done & ~rst;
    assign advance   = ~im_stall & ~dm_stall;
    assign owner_req = (owner == OWN_DM) ? dm_req : im_req;

    // Arbitration FSM: grant, one-cycle chip-select pulse, latency wait, capture into the owner's result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_IM;
            cnt      <= 3'd0;
            im_done  <= 1'b0;
            dm_done  <= 1'b0;
            mem_cs   <= 1'b0;
            mem_web  <= 1'b1;
            mem_bweb <= 4'hF;
            mem_addr <= '0;
            mem_di   <= 32'd0;
            im_rdata <= 32'd0;
            dm_rdata <= 32'd0;
        end else begin
            // Pipeline moved on: completed results are consumed, so both ports may request again.
            if (advance) begin
                im_done <= 1'b0;
                dm_done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (dm_stall) begin
                        owner    <= OWN_DM;
                        mem_cs   <= 1'b1;
                        mem_web  <= ~dm_we;
                        mem_bweb <= dm_we ? dm_bweb : 4'hF;
                        mem_addr <= dm_addr[ADDR_W+1:2];
                        mem_di   <= dm_wdata;
                        state    <= ISSUE;
                    end else if (im_stall) begin
                        owner    <= OWN_IM;
                        mem_cs   <= 1'b1;
                        mem_web  <= 1'b1;
                        mem_bweb <= 4'hF;
                        mem_addr <= im_addr[ADDR_W+1:2];
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_cs <= 1'b0;
                    cnt    <= CNT_INIT;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        // A requester that withdrew gets nothing: result dropped, done left clear.
                        if (owner_req) begin
                            if (owner == OWN_DM) begin
                                dm_done <= 1'b1;
                                if (mem_web) begin
                                    dm_rdata <= mem_do;
                                end
                            end else begin
                                im_done  <= 1'b1;
                                im_rdata <= mem_do;
                            end
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: two arbiters (MEM_LAT=1 and MEM_LAT=3) driven by the same directed vectors,
// each with its own SRAM, checked every cycle against a transaction-timing model
// plus literal expectations for the documented scenarios.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_bweb;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;

    logic [31:0] im_rdata [2];
    logic        im_stall [2];
    logic [31:0] dm_rdata [2];
    logic        dm_stall [2];
    logic        mem_cs   [2];
    logic        mem_web  [2];
    logic [3:0]  mem_bweb [2];
    logic [13:0] mem_addr [2];
    logic [31:0] mem_di   [2];
    logic [31:0] mem_do   [2];

    mem_port_arbiter #(.MEM_LAT(1), .ADDR_W(14)) u_lat1 (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata[0]), .im_stall(im_stall[0]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_bweb(dm_bweb), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata[0]), .dm_stall(dm_stall[0]),
        .mem_cs(mem_cs[0]), .mem_web(mem_web[0]), .mem_bweb(mem_bweb[0]),
        .mem_addr(mem_addr[0]), .mem_di(mem_di[0]), .mem_do(mem_do[0])
    );

    mem_port_arbiter #(.MEM_LAT(3), .ADDR_W(14)) u_lat3 (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata[1]), .im_stall(im_stall[1]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_bweb(dm_bweb), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata[1]), .dm_stall(dm_stall[1]),
        .mem_cs(mem_cs[1]), .mem_web(mem_web[1]), .mem_bweb(mem_bweb[1]),
        .mem_addr(mem_addr[1]), .mem_di(mem_di[1]), .mem_do(mem_do[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (MEM_LAT=%0d) t=%0t: got %h, expected %h", name, lat_of(k), $time, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] bwb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (!bwb[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // ---------------- SRAM models: write at issue edge, read data after MEM_LAT edges ----------------
    logic [31:0] sram [2][256];
    logic [31:0] pipe [2][3];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_cs[k] === 1'b1 && mem_web[k] === 1'b0)
                sram[k][mem_addr[k][7:0]] <= merge(sram[k][mem_addr[k][7:0]], mem_di[k], mem_bweb[k]);
            pipe[k][0] <= (mem_cs[k] === 1'b1 && mem_web[k] === 1'b1) ? sram[k][mem_addr[k][7:0]] : 32'hDEAD_BEEF;
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end

    always_comb begin
        mem_do[0] = pipe[0][0];
        mem_do[1] = pipe[1][2];
    end

    // ---------------- Transaction-timing model ----------------
    bit          m_valid [2];
    bit          m_imd   [2];
    bit          m_dmd   [2];
    bit          busy    [2];
    bit          a_dm    [2];
    bit          a_we    [2];
    int          a_start [2];
    int          cyc     [2];
    logic [31:0] a_addr  [2];
    logic [31:0] a_wd    [2];
    logic [3:0]  a_bw    [2];
    logic [31:0] m_imr   [2];
    logic [31:0] m_dmr   [2];
    logic [31:0] shadow  [2][256];

    function automatic bit e_im(input int k);
        return im_req && !m_imd[k] && !rst;
    endfunction

    function automatic bit e_dm(input int k);
        return dm_req && !m_dmd[k] && !rst;
    endfunction

    // Compare on the falling edge, then advance the model across the coming rising edge.
    initial begin
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0; busy[k] = 0; cyc[k] = 0;
            m_imd[k] = 0; m_dmd[k] = 0; m_imr[k] = 0; m_dmr[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                bit si, sd, ecs;
                si  = e_im(k);
                sd  = e_dm(k);
                ecs = busy[k] && (cyc[k] == a_start[k] + 1);
                if (m_valid[k]) begin
                    chk("im_stall", k, 32'(im_stall[k]), 32'(si));
                    chk("dm_stall", k, 32'(dm_stall[k]), 32'(sd));
                    chk("mem_cs", k, 32'(mem_cs[k]), 32'(ecs));
                    if (ecs) begin
                        chk("mem_addr", k, 32'(mem_addr[k]), 32'(a_addr[k][15:2]));
                        chk("mem_web", k, 32'(mem_web[k]), 32'(!(a_dm[k] && a_we[k])));
                        chk("mem_bweb", k, 32'(mem_bweb[k]), 32'((a_dm[k] && a_we[k]) ? a_bw[k] : 4'hF));
                        if (a_dm[k]) chk("mem_di", k, mem_di[k], a_wd[k]);
                    end
                    if (im_req && !si) chk("im_rdata", k, im_rdata[k], m_imr[k]);
                    if (dm_req && !sd) chk("dm_rdata", k, dm_rdata[k], m_dmr[k]);
                end
                if (rst) begin
                    m_valid[k] = 1; busy[k] = 0;
                    m_imd[k] = 0; m_dmd[k] = 0; m_imr[k] = 0; m_dmr[k] = 0;
                end else if (m_valid[k]) begin
                    if (!si && !sd) begin
                        m_imd[k] = 0; m_dmd[k] = 0;
                    end
                    if (busy[k]) begin
                        if (cyc[k] == a_start[k] + 1 && a_dm[k] && a_we[k])
                            shadow[k][a_addr[k][9:2]] = merge(shadow[k][a_addr[k][9:2]], a_wd[k], a_bw[k]);
                        if (cyc[k] == a_start[k] + 1 + lat_of(k)) begin
                            if (a_dm[k] ? dm_req : im_req) begin
                                if (a_dm[k]) begin
                                    if (!a_we[k]) m_dmr[k] = shadow[k][a_addr[k][9:2]];
                                    m_dmd[k] = 1;
                                end else begin
                                    m_imr[k] = shadow[k][a_addr[k][9:2]];
                                    m_imd[k] = 1;
                                end
                            end
                            busy[k] = 0;
                        end
                    end else if (sd || si) begin
                        busy[k]    = 1;
                        a_dm[k]    = sd;
                        a_start[k] = cyc[k];
                        a_we[k]    = sd ? dm_we : 1'b0;
                        a_addr[k]  = sd ? dm_addr : im_addr;
                        a_bw[k]    = dm_bweb;
                        a_wd[k]    = dm_wdata;
                    end
                end
                cyc[k] = cyc[k] + 1;
            end
        end
    end

    // ---------------- Directed stimulus with literal expectations ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          fc   [2];
        int          fc2  [2];
        int          scnt [2];
        int          low  [2];
        int          dlow [2];
        int          adv  [2];
        int          ncs  [2];
        logic [31:0] a1   [2];
        logic [31:0] a2   [2];
        logic [31:0] rd   [2];
        logic [31:0] drd  [2];
        logic [31:0] vadv [2];
        logic [31:0] iadv [2];
        logic [31:0] sweb [2];
        logic [31:0] sbw  [2];
        logic [31:0] sdi  [2];

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) begin
                sram[k][i]   = 32'h1000_0000 + 32'(i);
                shadow[k][i] = 32'h1000_0000 + 32'(i);
            end
            sram[k][4]   = 32'h0000_0013;
            shadow[k][4] = 32'h0000_0013;
            for (int j = 0; j < 3; j++) pipe[k][j] = 32'hDEAD_BEEF;
        end

        // Reset with both requests high: stalls must be forced low.
        rst = 1; im_req = 1; im_addr = 32'h10; dm_req = 1; dm_we = 0;
        dm_bweb = 4'hF; dm_addr = 32'h0; dm_wdata = 32'h0;
        repeat (3) nxt();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst mem_cs", k, 32'(mem_cs[k]), 32'd0);
            chk("rst mem_web", k, 32'(mem_web[k]), 32'd1);
            chk("rst mem_bweb", k, 32'(mem_bweb[k]), 32'hF);
            chk("rst mem_addr", k, 32'(mem_addr[k]), 32'd0);
            chk("rst mem_di", k, mem_di[k], 32'd0);
            chk("rst im_rdata", k, im_rdata[k], 32'd0);
            chk("rst dm_rdata", k, dm_rdata[k], 32'd0);
            chk("rst im_stall", k, 32'(im_stall[k]), 32'd0);
            chk("rst dm_stall", k, 32'(dm_stall[k]), 32'd0);
        end

        // Fetch only (also the latency sweep on the MEM_LAT=3 instance).
        nxt();
        rst = 0; dm_req = 0; im_req = 1; im_addr = 32'h0000_0010;
        for (int k = 0; k < 2; k++) begin fc[k] = -1; low[k] = -1; scnt[k] = 0; a1[k] = 0; rd[k] = 0; end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (mem_cs[k] && fc[k] < 0) begin fc[k] = n; a1[k] = 32'(mem_addr[k]); end
                if (low[k] < 0) begin
                    if (im_stall[k]) scnt[k]++;
                    else begin low[k] = n; rd[k] = im_rdata[k]; end
                end
            end
            nxt();
        end
        chk("fetch cs cycle", 0, 32'(fc[0]), 32'd1);
        chk("fetch mem_addr", 0, a1[0], 32'd4);
        chk("fetch stall cycles", 0, 32'(scnt[0]), 32'd3);
        chk("fetch ready cycle", 0, 32'(low[0]), 32'd3);
        chk("fetch im_rdata", 0, rd[0], 32'h0000_0013);
        chk("sweep cs cycle", 1, 32'(fc[1]), 32'd1);
        chk("sweep stall cycles", 1, 32'(scnt[1]), 32'd5);
        chk("sweep im_rdata", 1, rd[1], 32'h0000_0013);
        im_req = 0;
        repeat (8) nxt();

        // Contention, also the no-reissue check while im_stall keeps the pipeline frozen.
        im_req = 1; im_addr = 32'h8; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
        for (int k = 0; k < 2; k++) begin
            fc[k] = -1; fc2[k] = -1; adv[k] = -1; dlow[k] = -1; ncs[k] = 0;
            a1[k] = 0; a2[k] = 0; drd[k] = 0; vadv[k] = 0; iadv[k] = 0;
        end
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (adv[k] < 0) begin
                    if (mem_cs[k]) begin
                        ncs[k]++;
                        if (fc[k] < 0) begin fc[k] = n; a1[k] = 32'(mem_addr[k]); end
                        else if (fc2[k] < 0) begin fc2[k] = n; a2[k] = 32'(mem_addr[k]); end
                    end
                    if (dlow[k] < 0 && !dm_stall[k]) begin dlow[k] = n; drd[k] = dm_rdata[k]; end
                    if (!im_stall[k] && !dm_stall[k]) begin adv[k] = n; vadv[k] = dm_rdata[k]; iadv[k] = im_rdata[k]; end
                end
            end
            nxt();
        end
        chk("cont first mem_addr", 0, a1[0], 32'h10);
        chk("cont second mem_addr", 0, a2[0], 32'h2);
        chk("cont advance cycle", 0, 32'(adv[0]), 32'd6);
        chk("cont dm ready cycle", 0, 32'(dlow[0]), 32'd3);
        chk("cont cs pulses", 0, 32'(ncs[0]), 32'd2);
        chk("cont dm_rdata at ready", 0, drd[0], 32'h1000_0010);
        chk("cont dm_rdata at advance", 0, vadv[0], 32'h1000_0010);
        chk("cont im_rdata at advance", 0, iadv[0], 32'h1000_0002);
        chk("cont advance cycle", 1, 32'(adv[1]), 32'd10);
        chk("cont dm ready cycle", 1, 32'(dlow[1]), 32'd5);
        chk("cont cs pulses", 1, 32'(ncs[1]), 32'd2);
        chk("cont dm_rdata at advance", 1, vadv[1], 32'h1000_0010);
        im_req = 0; dm_req = 0;
        repeat (12) nxt();

        // Byte store.
        dm_req = 1; dm_we = 1; dm_bweb = 4'b1110; dm_wdata = 32'hAABB_CCDD; dm_addr = 32'h100;
        for (int k = 0; k < 2; k++) begin fc[k] = -1; dlow[k] = -1; drd[k] = 0; sweb[k] = 0; sbw[k] = 0; a1[k] = 0; sdi[k] = 0; end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (mem_cs[k] && fc[k] < 0) begin
                    fc[k] = n; sweb[k] = 32'(mem_web[k]); sbw[k] = 32'(mem_bweb[k]);
                    a1[k] = 32'(mem_addr[k]); sdi[k] = mem_di[k];
                end
                if (dlow[k] < 0 && !dm_stall[k]) begin dlow[k] = n; drd[k] = dm_rdata[k]; end
            end
            nxt();
        end
        for (int k = 0; k < 2; k++) begin
            chk("store mem_web", k, sweb[k], 32'd0);
            chk("store mem_bweb", k, sbw[k], 32'hE);
            chk("store mem_addr", k, a1[k], 32'h40);
            chk("store mem_di", k, sdi[k], 32'hAABB_CCDD);
            chk("store dm_rdata kept", k, drd[k], 32'h1000_0010);
        end
        dm_req = 0;
        repeat (8) nxt();

        // Read the stored word back.
        dm_req = 1; dm_we = 0; dm_bweb = 4'hF; dm_addr = 32'h100;
        for (int k = 0; k < 2; k++) begin dlow[k] = -1; drd[k] = 0; end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                if (dlow[k] < 0 && !dm_stall[k]) begin dlow[k] = n; drd[k] = dm_rdata[k]; end
            nxt();
        end
        for (int k = 0; k < 2; k++) chk("readback dm_rdata", k, drd[k], 32'h1000_00DD);
        dm_req = 0;
        repeat (8) nxt();

        // Reset mid-access, then a fresh fetch.
        im_req = 1; im_addr = 32'h20;
        @(negedge clk); nxt();
        @(negedge clk); nxt();
        rst = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("midrst im_stall", k, 32'(im_stall[k]), 32'd0);
            chk("midrst dm_stall", k, 32'(dm_stall[k]), 32'd0);
        end
        nxt();
        rst = 0;
        for (int k = 0; k < 2; k++) begin fc[k] = -1; low[k] = -1; rd[k] = 0; end
        for (int n = 3; n < 13; n++) begin
            @(negedge clk);
            if (n == 3) begin
                for (int k = 0; k < 2; k++) begin
                    chk("postrst mem_cs", k, 32'(mem_cs[k]), 32'd0);
                    chk("postrst im_stall", k, 32'(im_stall[k]), 32'd1);
                    chk("postrst im_rdata", k, im_rdata[k], 32'd0);
                    chk("postrst dm_rdata", k, dm_rdata[k], 32'd0);
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (mem_cs[k] && fc[k] < 0) fc[k] = n;
                if (low[k] < 0 && !im_stall[k]) begin low[k] = n; rd[k] = im_rdata[k]; end
            end
            nxt();
        end
        chk("refetch cs cycle", 0, 32'(fc[0]), 32'd4);
        chk("refetch ready cycle", 0, 32'(low[0]), 32'd6);
        chk("refetch im_rdata", 0, rd[0], 32'h1000_0008);
        chk("refetch cs cycle", 1, 32'(fc[1]), 32'd4);
        chk("refetch ready cycle", 1, 32'(low[1]), 32'd8);
        chk("refetch im_rdata", 1, rd[1], 32'h1000_0008);
        im_req = 0;
        repeat (10) nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
